// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: loads a six-symbol code table, then decodes one bit per
// cycle into gray symbols 1..6 with saturating per-symbol counts and sticky errors.
module huffman_decoder #(
  parameter int CODE_W = 8,
  parameter int SCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              sym_valid,
  output logic [7:0]        sym_data,
  output logic [SCNT_W-1:0] DCNT1,
  output logic [SCNT_W-1:0] DCNT2,
  output logic [SCNT_W-1:0] DCNT3,
  output logic [SCNT_W-1:0] DCNT4,
  output logic [SCNT_W-1:0] DCNT5,
  output logic [SCNT_W-1:0] DCNT6,
  output logic              tbl_err,
  output logic              dec_err
);

  localparam int LEN_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ERR} state_t;

  state_t            r_state, w_next;
  logic [CODE_W-1:0] r_hc   [6];
  logic [CODE_W-1:0] r_m    [6];
  logic [SCNT_W-1:0] r_dcnt [6];
  logic [CODE_W-1:0] r_acc;
  logic [LEN_W-1:0]  r_len;
  logic              r_sym_valid, r_tbl_err, r_dec_err;
  logic [7:0]        r_sym_data;

  logic [CODE_W-1:0] w_in_hc [6];
  logic [CODE_W-1:0] w_in_m  [6];
  logic              w_tbl_ok, w_xfer, w_hit, w_full;
  logic [CODE_W-1:0] w_new_acc;
  logic [LEN_W-1:0]  w_new_len;
  logic [2:0]        w_idx;

  function automatic logic mask_ok(input logic [CODE_W-1:0] m);
    mask_ok = (m != '0) && ((m & (m + CODE_W'(1))) == '0);
  endfunction

  function automatic logic [LEN_W-1:0] popcnt(input logic [CODE_W-1:0] m);
    popcnt = '0;
    for (int k = 0; k < CODE_W; k++) popcnt = popcnt + LEN_W'(m[k]);
  endfunction

  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] c);
    sat_inc = (&c) ? c : c + SCNT_W'(1);
  endfunction

  assign w_in_hc[0] = HC1;  assign w_in_m[0] = M1;
  assign w_in_hc[1] = HC2;  assign w_in_m[1] = M2;
  assign w_in_hc[2] = HC3;  assign w_in_m[2] = M3;
  assign w_in_hc[3] = HC4;  assign w_in_m[3] = M4;
  assign w_in_hc[4] = HC5;  assign w_in_m[4] = M5;
  assign w_in_hc[5] = HC6;  assign w_in_m[5] = M6;

  always_comb begin
    w_tbl_ok = 1'b1;
    for (int i = 0; i < 6; i++) w_tbl_ok = w_tbl_ok & mask_ok(w_in_m[i]);
  end

  assign w_xfer    = bit_ready & bit_valid;
  // Bits above r_len are always zero, so OR-ing places bit_in at position r_len.
  assign w_new_acc = r_acc | (CODE_W'(bit_in) << r_len);
  assign w_new_len = r_len + LEN_W'(1);
  assign w_full    = (w_new_len == LEN_W'(CODE_W));

  // Scan downwards so the lowest matching index wins on non-prefix-free tables.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (w_new_len == popcnt(r_m[i]) && ((w_new_acc & r_m[i]) == (r_hc[i] & r_m[i]))) begin
        w_hit = 1'b1;
        w_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_ERR: if (code_valid) w_next = w_tbl_ok ? S_DECODE : S_ERR;
      S_DECODE: begin
        if (code_valid)                     w_next = w_tbl_ok ? S_DECODE : S_ERR;
        else if (w_xfer && !w_hit && w_full) w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bit_ready = (r_state == S_DECODE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sym_valid <= 1'b0;
      r_sym_data  <= '0;
      r_tbl_err   <= 1'b0;
      r_dec_err   <= 1'b0;
      r_acc       <= '0;
      r_len       <= '0;
      for (int i = 0; i < 6; i++) begin
        r_hc[i]   <= '0;
        r_m[i]    <= '0;
        r_dcnt[i] <= '0;
      end
    end else begin
      r_sym_valid <= 1'b0;
      if (code_valid) begin
        r_tbl_err <= ~w_tbl_ok;
        r_dec_err <= 1'b0;
        r_acc     <= '0;
        r_len     <= '0;
        for (int i = 0; i < 6; i++) begin
          r_hc[i]   <= w_in_hc[i];
          r_m[i]    <= w_in_m[i];
          r_dcnt[i] <= '0;
        end
      end else if (w_xfer) begin
        if (w_hit) begin
          r_sym_valid <= 1'b1;
          r_sym_data  <= 8'(w_idx) + 8'd1;
          r_acc       <= '0;
          r_len       <= '0;
          for (int i = 0; i < 6; i++)
            if (w_idx == 3'(i)) r_dcnt[i] <= sat_inc(r_dcnt[i]);
        end else if (w_full) begin
          r_dec_err <= 1'b1;
          r_acc     <= '0;
          r_len     <= '0;
        end else begin
          r_acc <= w_new_acc;
          r_len <= w_new_len;
        end
      end
    end
  end

  assign sym_valid = r_sym_valid;
  assign sym_data  = r_sym_data;
  assign tbl_err   = r_tbl_err;
  assign dec_err   = r_dec_err;
  assign DCNT1     = r_dcnt[0];
  assign DCNT2     = r_dcnt[1];
  assign DCNT3     = r_dcnt[2];
  assign DCNT4     = r_dcnt[3];
  assign DCNT5     = r_dcnt[4];
  assign DCNT6     = r_dcnt[5];

endmodule

// File: tb/tb_huffman_decoder.sv
// Bench for huffman_decoder: directed scenarios plus randomized tables and bit streams,
// every cycle compared against a bit-list reference model.
module tb_huffman_decoder;
  localparam int CODE_W = 8;
  localparam int SCNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset, code_valid, bit_valid, bit_in;
  logic [CODE_W-1:0] t_hc [6];
  logic [CODE_W-1:0] t_m  [6];
  logic              bit_ready, sym_valid, tbl_err, dec_err;
  logic [7:0]        sym_data;
  logic [SCNT_W-1:0] d [6];

  huffman_decoder #(.CODE_W(CODE_W), .SCNT_W(SCNT_W)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(t_hc[0]), .HC2(t_hc[1]), .HC3(t_hc[2]), .HC4(t_hc[3]), .HC5(t_hc[4]), .HC6(t_hc[5]),
    .M1(t_m[0]), .M2(t_m[1]), .M3(t_m[2]), .M4(t_m[3]), .M5(t_m[4]), .M6(t_m[5]),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data),
    .DCNT1(d[0]), .DCNT2(d[1]), .DCNT3(d[2]), .DCNT4(d[3]), .DCNT5(d[4]), .DCNT6(d[5]),
    .tbl_err(tbl_err), .dec_err(dec_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: 0 = idle, 1 = decoding, 2 = error
  int         m_mode;
  logic [7:0] m_hc [6];
  logic [7:0] m_m  [6];
  int         m_cnt [6];
  bit         m_sv, m_te, m_de;
  int         m_sd;
  bit         m_bits [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones(input logic [7:0] m);
    int n = 0;
    for (int k = 0; k < 8; k++) n += int'(m[k]);
    return n;
  endfunction

  function automatic bit legal(input logic [7:0] m);
    int l = ones(m);
    return (l > 0) && (int'(m) == (1 << l) - 1);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_sv = 0; m_sd = 0; m_te = 0; m_de = 0;
    m_bits.delete();
    for (int i = 0; i < 6; i++) begin m_hc[i] = 0; m_m[i] = 0; m_cnt[i] = 0; end
  endtask

  task automatic model_step(input bit r, input bit cv, input bit bv, input bit bi);
    bit ok, found;
    int idx;
    if (r) begin model_reset(); return; end
    m_sv = 0;
    if (cv) begin
      ok = 1;
      for (int i = 0; i < 6; i++) begin
        m_hc[i] = t_hc[i]; m_m[i] = t_m[i]; m_cnt[i] = 0;
        if (!legal(t_m[i])) ok = 0;
      end
      m_bits.delete();
      m_te = !ok; m_de = 0;
      m_mode = ok ? 1 : 2;
    end else if (m_mode == 1 && bv) begin
      m_bits.push_back(bi);
      found = 0; idx = 0;
      for (int i = 0; i < 6; i++) begin
        if (!found && m_bits.size() == ones(m_m[i])) begin
          ok = 1;
          for (int j = 0; j < m_bits.size(); j++) if (m_bits[j] != m_hc[i][j]) ok = 0;
          if (ok) begin found = 1; idx = i; end
        end
      end
      if (found) begin
        m_sv = 1; m_sd = idx + 1;
        if (m_cnt[idx] < 255) m_cnt[idx]++;
        m_bits.delete();
      end else if (m_bits.size() == CODE_W) begin
        m_mode = 2; m_de = 1;
        m_bits.delete();
      end
    end
  endtask

  task automatic step(input bit r, input bit cv, input bit bv, input bit bi);
    reset = r; code_valid = cv; bit_valid = bv; bit_in = bi;
    chk("bit_ready_pre", {31'd0, bit_ready}, {31'd0, m_mode == 1});
    @(posedge clk);
    model_step(r, cv, bv, bi);
    #1;
    chk("sym_valid", {31'd0, sym_valid}, {31'd0, m_sv});
    chk("sym_data", {24'd0, sym_data}, m_sd);
    chk("tbl_err", {31'd0, tbl_err}, {31'd0, m_te});
    chk("dec_err", {31'd0, dec_err}, {31'd0, m_de});
    chk("bit_ready", {31'd0, bit_ready}, {31'd0, m_mode == 1});
    for (int i = 0; i < 6; i++) chk($sformatf("DCNT%0d", i + 1), {24'd0, d[i]}, m_cnt[i]);
    reset = 0; code_valid = 0; bit_valid = 0;
  endtask

  task automatic send(input bit b);  step(0, 0, 1, b); endtask
  task automatic idle();             step(0, 0, 0, 0); endtask

  task automatic load_a();
    logic [7:0] hc [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00};
    logic [7:0] m  [6] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h1F};
    for (int i = 0; i < 6; i++) begin t_hc[i] = hc[i]; t_m[i] = m[i]; end
    step(0, 1, 0, 0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int j = 0; j < n; j++) send(v[j]);
  endtask

  task automatic rand_table();
    for (int i = 0; i < 6; i++) begin
      int l = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8) : $urandom_range(1, 3);
      t_m[i]  = 8'((1 << l) - 1);
      if ($urandom_range(0, 9) == 0) t_m[i] = 8'($urandom);
      t_hc[i] = 8'($urandom);
    end
  endtask

  initial begin
    model_reset();
    reset = 1; code_valid = 0; bit_valid = 0; bit_in = 0;
    for (int i = 0; i < 6; i++) begin t_hc[i] = 0; t_m[i] = 0; end
    @(posedge clk); @(posedge clk); #1;
    step(1, 0, 0, 0);
    chk("rst_bit_ready", {31'd0, bit_ready}, 32'd0);

    // Back-to-back stream 1,0,1,0,0,0,0,0 -> symbols 1, 2, 6
    load_a();
    send(1); chk("t1_sym1", {24'd0, sym_data}, 32'd1);
    send(0); send(1); chk("t1_sym2", {24'd0, sym_data}, 32'd2);
    for (int j = 0; j < 5; j++) send(0);
    chk("t1_sym6", {24'd0, sym_data}, 32'd6);
    chk("t1_dcnt6", {24'd0, d[5]}, 32'd1);

    // Idle gap inside the stream
    send_bits(8'h08, 4); idle(); idle(); idle();
    send_bits(8'h04, 3); chk("t2_sym3", {24'd0, sym_data}, 32'd3);

    // Decode error with an 8-bit window of zeros
    load_a(); t_hc[5] = 8'h20; t_m[5] = 8'h3F; step(0, 1, 0, 0);
    for (int j = 0; j < 8; j++) send(0);
    chk("t3_dec_err", {31'd0, dec_err}, 32'd1);
    load_a(); chk("t3_cleared", {31'd0, dec_err}, 32'd0);

    // Illegal mask
    t_m[2] = 8'h05; step(0, 1, 0, 0);
    chk("t4_tbl_err", {31'd0, tbl_err}, 32'd1);
    for (int j = 0; j < 4; j++) send(j[0]);

    // Reload mid-codeword discards the partial bits
    load_a(); send(0); send(0);
    load_a(); send_bits(8'h04, 3);
    chk("t5_sym3", {24'd0, sym_data}, 32'd3);

    // 100 symbols, then reset mid-codeword
    for (int s = 0; s < 100; s++) begin
      int k = $urandom_range(0, 5);
      send_bits(t_hc[k], ones(t_m[k]));
      if ($urandom_range(0, 3) == 0) idle();
    end
    send(0); send(0);
    step(1, 0, 1, 0);
    chk("t6_rst_dcnt1", {24'd0, d[0]}, 32'd0);
    for (int j = 0; j < 5; j++) send(1);

    // Counter saturation on a one-bit code
    load_a(); t_hc[0] = 8'h00; step(0, 1, 0, 0);
    for (int j = 0; j < 300; j++) send(0);
    chk("t7_sat", {24'd0, d[0]}, 32'd255);

    // Randomized tables and streams, including reloads and resets mid-stream
    for (int it = 0; it < 25; it++) begin
      rand_table(); step(0, 1, 0, 0);
      for (int c = 0; c < 120; c++) begin
        bit r  = ($urandom_range(0, 199) == 0);
        bit cv = ($urandom_range(0, 79) == 0) || (m_mode != 1 && $urandom_range(0, 9) == 0);
        if (cv) rand_table();
        step(r, cv, $urandom_range(0, 3) != 0, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
